// File: rtl/multicycle_maindec.sv
// Multicycle RV32 main decoder: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with optional F-extension ops that handshake with a multicycle FPU via fp_start/fp_done.
module multicycle_maindec #(
   parameter bit FP_EN  = 1'b1,
   parameter bit MEM_HS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       fp_done,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       RegWrite,
   output logic       FRegWrite,
   output logic       FpSel,
   output logic       fp_start,
   output logic       illegal,
   output logic [3:0] dbgState
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11,
      FPEXEC   = 4'd12,
      FPWB     = 4'd13
   } stateT;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_FLW = 7'b0000111;
   localparam logic [6:0] OP_FSW = 7'b0100111;
   localparam logic [6:0] OP_FP  = 7'b1010011;

   stateT state, nextState, cur;
   logic  fpSel, fpFirst;
   logic  memRdy, pcUpdate, branch;
   logic  isFlw, isFsw, isFpOp, isLoad, isStore;

   assign memRdy  = MEM_HS ? mem_ready : 1'b1;
   assign isFlw   = FP_EN & (op == OP_FLW);
   assign isFsw   = FP_EN & (op == OP_FSW);
   assign isFpOp  = FP_EN & (op == OP_FP);
   assign isLoad  = (op == OP_LW) | isFlw;
   assign isStore = (op == OP_SW) | isFsw;

   // While reset is low the outputs decode as FETCH regardless of the held state.
   assign cur      = reset ? state : FETCH;
   assign dbgState = cur;
   assign FpSel    = fpSel;
   assign PCWrite  = pcUpdate | (branch & zero);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= FETCH;
         fpSel   <= 1'b0;
         fpFirst <= 1'b0;
      end else begin
         state   <= nextState;
         fpFirst <= (state == DECODE) && (nextState == FPEXEC);
         if (state == DECODE) fpSel <= isFlw | isFsw | isFpOp;
      end
   end

   always_comb begin
      nextState = cur;
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      RegWrite  = 1'b0;
      FRegWrite = 1'b0;
      fp_start  = 1'b0;
      illegal   = 1'b0;
      case (cur)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = memRdy & reset;
            pcUpdate  = memRdy & reset;
            if (memRdy) nextState = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            if (isLoad | isStore)    nextState = MEMADR;
            else if (op == OP_R)     nextState = EXECUTER;
            else if (op == OP_I)     nextState = EXECUTEI;
            else if (op == OP_BEQ)   nextState = BEQ;
            else if (op == OP_JAL)   nextState = JAL;
            else if (op == OP_LUI)   nextState = LUI;
            else if (isFpOp)         nextState = FPEXEC;
            else begin
               nextState = FETCH;
               illegal   = 1'b1;
            end
         end
         MEMADR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            nextState = isLoad ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (memRdy) nextState = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = ~fpSel;
            FRegWrite = fpSel;
            nextState = FETCH;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (memRdy) nextState = FETCH;
         end
         EXECUTER: begin
            ALUSrcA   = 2'b10;
            ALUOp     = 2'b10;
            nextState = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ALUOp     = 2'b10;
            nextState = ALUWB;
         end
         LUI: begin
            ALUSrcA   = 2'b11;
            ALUSrcB   = 2'b01;
            nextState = ALUWB;
         end
         ALUWB: begin
            RegWrite  = 1'b1;
            nextState = FETCH;
         end
         BEQ: begin
            ALUSrcA   = 2'b10;
            ALUOp     = 2'b01;
            branch    = 1'b1;
            nextState = FETCH;
         end
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pcUpdate  = 1'b1;
            nextState = ALUWB;
         end
         FPEXEC: begin
            fp_start = fpFirst;
            if (fp_done) nextState = FPWB;
         end
         FPWB: begin
            ResultSrc = 2'b11;
            FRegWrite = 1'b1;
            nextState = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW, OP_FSW: ImmSrc = 3'b001;
         OP_BEQ:        ImmSrc = 3'b010;
         OP_JAL:        ImmSrc = 3'b011;
         OP_LUI:        ImmSrc = 3'b100;
         default:       ImmSrc = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: per-cycle expected control words (hand-built from the state
// table) are queued as stimulus is applied and compared against the packed DUT outputs.
module tb_multicycle_maindec;

   localparam logic [3:0] sFetch = 4'd0,  sDecode = 4'd1,  sMemAdr = 4'd2,  sMemRead = 4'd3;
   localparam logic [3:0] sMemWb = 4'd4,  sMemWrite = 4'd5, sExecR = 4'd6,  sExecI = 4'd7;
   localparam logic [3:0] sAluWb = 4'd8,  sBeq = 4'd9,     sJal = 4'd10,   sLui = 4'd11;
   localparam logic [3:0] sFpExec = 4'd12, sFpWb = 4'd13;

   localparam logic [6:0] opLw = 7'b0000011, opSw = 7'b0100011, opR = 7'b0110011;
   localparam logic [6:0] opI = 7'b0010011, opBeq = 7'b1100011, opJal = 7'b1101111;
   localparam logic [6:0] opLui = 7'b0110111, opFlw = 7'b0000111, opFp = 7'b1010011;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] op = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       fp_done = 1'b0;

   logic       aPCWrite, aAdrSrc, aMemWrite, aIRWrite, aRegWrite, aFRegWrite, aFpSel, aFpStart, aIllegal;
   logic [1:0] aResultSrc, aALUSrcA, aALUSrcB, aALUOp;
   logic [2:0] aImmSrc;
   logic [3:0] aState;
   logic       bPCWrite, bAdrSrc, bMemWrite, bIRWrite, bRegWrite, bFRegWrite, bFpSel, bFpStart, bIllegal;
   logic [1:0] bResultSrc, bALUSrcA, bALUSrcB, bALUOp;
   logic [2:0] bImmSrc;
   logic [3:0] bState;

   logic [23:0] obsA, obsB;
   logic [23:0] expQ[$];
   int          nChecks = 0;
   int          nErrors = 0;

   always #5 clk = ~clk;

   multicycle_maindec #(.FP_EN(1'b1), .MEM_HS(1'b1)) dutA (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready), .fp_done(fp_done),
      .PCWrite(aPCWrite), .AdrSrc(aAdrSrc), .MemWrite(aMemWrite), .IRWrite(aIRWrite),
      .ResultSrc(aResultSrc), .ALUSrcA(aALUSrcA), .ALUSrcB(aALUSrcB), .ALUOp(aALUOp),
      .ImmSrc(aImmSrc), .RegWrite(aRegWrite), .FRegWrite(aFRegWrite), .FpSel(aFpSel),
      .fp_start(aFpStart), .illegal(aIllegal), .dbgState(aState)
   );

   multicycle_maindec #(.FP_EN(1'b0), .MEM_HS(1'b0)) dutB (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready), .fp_done(fp_done),
      .PCWrite(bPCWrite), .AdrSrc(bAdrSrc), .MemWrite(bMemWrite), .IRWrite(bIRWrite),
      .ResultSrc(bResultSrc), .ALUSrcA(bALUSrcA), .ALUSrcB(bALUSrcB), .ALUOp(bALUOp),
      .ImmSrc(bImmSrc), .RegWrite(bRegWrite), .FRegWrite(bFRegWrite), .FpSel(bFpSel),
      .fp_start(bFpStart), .illegal(bIllegal), .dbgState(bState)
   );

   assign obsA = {aState, aPCWrite, aAdrSrc, aMemWrite, aIRWrite, aResultSrc, aALUSrcA, aALUSrcB,
                  aALUOp, aImmSrc, aRegWrite, aFRegWrite, aFpSel, aFpStart, aIllegal};
   assign obsB = {bState, bPCWrite, bAdrSrc, bMemWrite, bIRWrite, bResultSrc, bALUSrcA, bALUSrcB,
                  bALUOp, bImmSrc, bRegWrite, bFRegWrite, bFpSel, bFpStart, bIllegal};

   // Expected control word for one cycle in a given state.
   function automatic logic [23:0] ew(input logic [3:0] st, input logic mr, input logic z,
                                      input logic fps, input logic fst, input logic [2:0] imm,
                                      input logic ill);
      logic       pcw, adr, mw, irw, rw, frw;
      logic [1:0] rs, sa, sb, ao;
      pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; frw = 1'b0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
      case (st)
         sFetch:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         sDecode:   begin sa = 2'b01; sb = 2'b01; end
         sMemAdr:   begin sa = 2'b10; sb = 2'b01; end
         sMemRead:  adr = 1'b1;
         sMemWb:    begin rs = 2'b01; rw = ~fps; frw = fps; end
         sMemWrite: begin adr = 1'b1; mw = 1'b1; end
         sExecR:    begin sa = 2'b10; ao = 2'b10; end
         sExecI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         sLui:      begin sa = 2'b11; sb = 2'b01; end
         sAluWb:    rw = 1'b1;
         sBeq:      begin sa = 2'b10; ao = 2'b01; pcw = z; end
         sJal:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         sFpWb:     begin rs = 2'b11; frw = 1'b1; end
         default:   ;
      endcase
      return {st, pcw, adr, mw, irw, rs, sa, sb, ao, imm, rw, frw, fps, fst, ill};
   endfunction

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: queue expectations, sample mid-cycle, advance past the next edge.
   task automatic step(input string tag, input logic [23:0] ea, input bit doA,
                       input logic [23:0] eb, input bit doB);
      if (doA) expQ.push_back(ea);
      if (doB) expQ.push_back(eb);
      @(negedge clk);
      if (doA) check({tag, "/a"}, obsA, expQ.pop_front());
      if (doB) check({tag, "/b"}, obsB, expQ.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [23:0] e);
      step(tag, e, 1'b1, 24'd0, 1'b0);
   endtask

   task automatic cycB(input string tag, input logic [23:0] e);
      step(tag, 24'd0, 1'b0, e, 1'b1);
   endtask

   task automatic doReset(input int n);
      reset = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int k;
      op = opLw;
      @(posedge clk);
      #1;
      step("rst1", ew(sFetch, 0, 0, 0, 0, 3'b000, 0), 1'b1, ew(sFetch, 0, 0, 0, 0, 3'b000, 0), 1'b1);
      step("rst2", ew(sFetch, 0, 0, 0, 0, 3'b000, 0), 1'b1, ew(sFetch, 0, 0, 0, 0, 3'b000, 0), 1'b1);
      reset = 1'b1;

      // lw, no waits
      cyc("lw1", ew(sFetch,   1, 0, 0, 0, 3'b000, 0));
      cyc("lw2", ew(sDecode,  1, 0, 0, 0, 3'b000, 0));
      cyc("lw3", ew(sMemAdr,  1, 0, 0, 0, 3'b000, 0));
      cyc("lw4", ew(sMemRead, 1, 0, 0, 0, 3'b000, 0));
      cyc("lw5", ew(sMemWb,   1, 0, 0, 0, 3'b000, 0));

      // sw with two memory wait cycles
      op = opSw;
      cyc("sw1", ew(sFetch,  1, 0, 0, 0, 3'b001, 0));
      cyc("sw2", ew(sDecode, 1, 0, 0, 0, 3'b001, 0));
      cyc("sw3", ew(sMemAdr, 1, 0, 0, 0, 3'b001, 0));
      mem_ready = 1'b0;
      cyc("sw4", ew(sMemWrite, 0, 0, 0, 0, 3'b001, 0));
      cyc("sw5", ew(sMemWrite, 0, 0, 0, 0, 3'b001, 0));
      mem_ready = 1'b1;
      cyc("sw6", ew(sMemWrite, 1, 0, 0, 0, 3'b001, 0));

      // lw with random fetch and read waits
      op = opLw;
      k = $urandom_range(0, 2);
      mem_ready = 1'b0;
      for (int i = 0; i < k; i++) cyc("lwr_fw", ew(sFetch, 0, 0, 0, 0, 3'b000, 0));
      mem_ready = 1'b1;
      cyc("lwr_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cyc("lwr_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 0));
      cyc("lwr_a", ew(sMemAdr, 1, 0, 0, 0, 3'b000, 0));
      k = $urandom_range(0, 3);
      mem_ready = 1'b0;
      for (int i = 0; i < k; i++) cyc("lwr_rw", ew(sMemRead, 0, 0, 0, 0, 3'b000, 0));
      mem_ready = 1'b1;
      cyc("lwr_r", ew(sMemRead, 1, 0, 0, 0, 3'b000, 0));
      cyc("lwr_wb", ew(sMemWb,  1, 0, 0, 0, 3'b000, 0));

      // beq taken then not taken
      op = opBeq;
      for (int t = 1; t >= 0; t--) begin
         zero = 1'(t);
         cyc("beq_f", ew(sFetch,  1, 0, 0, 0, 3'b010, 0));
         cyc("beq_d", ew(sDecode, 1, 0, 0, 0, 3'b010, 0));
         cyc("beq_x", ew(sBeq,    1, 1'(t), 0, 0, 3'b010, 0));
      end

      // I-type and jal, with zero randomised where it must not matter
      op = opI;
      zero = 1'($urandom_range(0, 1));
      cyc("i_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cyc("i_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 0));
      cyc("i_x", ew(sExecI,  1, 0, 0, 0, 3'b000, 0));
      cyc("i_w", ew(sAluWb,  1, 0, 0, 0, 3'b000, 0));
      op = opJal;
      cyc("jal_f", ew(sFetch,  1, 0, 0, 0, 3'b011, 0));
      cyc("jal_d", ew(sDecode, 1, 0, 0, 0, 3'b011, 0));
      cyc("jal_x", ew(sJal,    1, 0, 0, 0, 3'b011, 0));
      cyc("jal_w", ew(sAluWb,  1, 0, 0, 0, 3'b011, 0));
      zero = 1'b0;

      // undecodable opcode
      op = 7'b1111111;
      cyc("ill_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cyc("ill_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 1));

      // OP-FP with fp_done four cycles after entry
      op = opFp;
      cyc("fp_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cyc("fp_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 0));
      cyc("fp_x0", ew(sFpExec, 1, 0, 1, 1, 3'b000, 0));
      for (int i = 1; i < 4; i++) cyc("fp_xw", ew(sFpExec, 1, 0, 1, 0, 3'b000, 0));
      fp_done = 1'b1;
      cyc("fp_x4", ew(sFpExec, 1, 0, 1, 0, 3'b000, 0));
      fp_done = 1'b0;
      cyc("fp_wb", ew(sFpWb,   1, 0, 1, 0, 3'b000, 0));

      // OP-FP with fp_done coincident with fp_start
      cyc("fpq_f", ew(sFetch,  1, 0, 1, 0, 3'b000, 0));
      cyc("fpq_d", ew(sDecode, 1, 0, 1, 0, 3'b000, 0));
      fp_done = 1'b1;
      cyc("fpq_x", ew(sFpExec, 1, 0, 1, 1, 3'b000, 0));
      fp_done = 1'b0;
      cyc("fpq_wb", ew(sFpWb,  1, 0, 1, 0, 3'b000, 0));

      // flw writes the FP regfile
      op = opFlw;
      cyc("flw_f", ew(sFetch,   1, 0, 1, 0, 3'b000, 0));
      cyc("flw_d", ew(sDecode,  1, 0, 1, 0, 3'b000, 0));
      cyc("flw_a", ew(sMemAdr,  1, 0, 1, 0, 3'b000, 0));
      cyc("flw_r", ew(sMemRead, 1, 0, 1, 0, 3'b000, 0));
      cyc("flw_wb", ew(sMemWb,  1, 0, 1, 0, 3'b000, 0));

      // R-type clears FpSel at decode
      op = opR;
      cyc("r_f", ew(sFetch,  1, 0, 1, 0, 3'b000, 0));
      cyc("r_d", ew(sDecode, 1, 0, 1, 0, 3'b000, 0));
      cyc("r_x", ew(sExecR,  1, 0, 0, 0, 3'b000, 0));
      cyc("r_w", ew(sAluWb,  1, 0, 0, 0, 3'b000, 0));

      // FP_EN=0 / MEM_HS=0 instance: FP opcodes illegal, mem_ready ignored
      doReset(2);
      op = opFp;
      mem_ready = 1'b0;
      cycB("nofp_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cycB("nofp_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 1));
      op = opFlw;
      cycB("noflw_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cycB("noflw_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 1));
      op = opLw;
      cycB("nhs_f",  ew(sFetch,   1, 0, 0, 0, 3'b000, 0));
      cycB("nhs_d",  ew(sDecode,  1, 0, 0, 0, 3'b000, 0));
      cycB("nhs_a",  ew(sMemAdr,  1, 0, 0, 0, 3'b000, 0));
      cycB("nhs_r",  ew(sMemRead, 1, 0, 0, 0, 3'b000, 0));
      cycB("nhs_wb", ew(sMemWb,   1, 0, 0, 0, 3'b000, 0));
      cycB("nhs_f2", ew(sFetch,   1, 0, 0, 0, 3'b000, 0));
      mem_ready = 1'b1;

      // reset in MEMREAD aborts the load, then lui
      doReset(2);
      op = opLw;
      cyc("ab_f", ew(sFetch,  1, 0, 0, 0, 3'b000, 0));
      cyc("ab_d", ew(sDecode, 1, 0, 0, 0, 3'b000, 0));
      cyc("ab_a", ew(sMemAdr, 1, 0, 0, 0, 3'b000, 0));
      reset = 1'b0;
      cyc("ab_rst", ew(sFetch, 0, 0, 0, 0, 3'b000, 0));
      reset = 1'b1;
      op = opLui;
      cyc("lui_f", ew(sFetch,  1, 0, 0, 0, 3'b100, 0));
      cyc("lui_d", ew(sDecode, 1, 0, 0, 0, 3'b100, 0));
      cyc("lui_x", ew(sLui,    1, 0, 0, 0, 3'b100, 0));
      cyc("lui_w", ew(sAluWb,  1, 0, 0, 0, 3'b100, 0));
      cyc("lui_f2", ew(sFetch, 1, 0, 0, 0, 3'b100, 0));

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/multicycle_maindec.md
# multicycle_maindec

- Parametrised multicycle successor to the single-cycle RV32 main decoder.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory, writeback.
- Decodes the integer subset (lw, sw, R-type, I-type ALU, beq, jal, lui) plus optional F-extension ops (flw, fsw, OP-FP) that use a start/done handshake with a multicycle FPU.
- Sits in the multicycle controller next to aludec; drives the shared-memory datapath.

## Interface
- FP_EN, 1, 1 enables flw/fsw/OP-FP decode; 0 treats those opcodes as illegal.
- MEM_HS, 1, 1 holds memory states until mem_ready; 0 ignores mem_ready (treated as 1).
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- op  in  7  instruction opcode, valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- fp_done  in  1  FPU result valid, single-cycle pulse.
- PCWrite  out  1  PCUpdate | (Branch & zero).
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 FPU result.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op.
- RegWrite  out  1  integer regfile write.
- FRegWrite  out  1  FP regfile write.
- FpSel  out  1  current instruction is F-class; selects FP store data.
- fp_start  out  1  one-cycle FPU launch pulse.
- illegal  out  1  one-cycle pulse on an undecodable opcode.

## Operation
- All outputs are 0 and unlisted fields are 0 in every state, except ImmSrc, which depends only on op.
- **FETCH**
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=mem_ready.
  - Goes to DECODE when mem_ready; otherwise stays.
- **DECODE**
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - Next state by op:
    - lw/sw/flw/fsw → MEMADR
    - R → EXECUTER
    - I → EXECUTEI
    - beq → BEQ
    - jal → JAL
    - lui → LUI
    - OP-FP → FPEXEC
    - other → FETCH, with illegal=1 this cycle.
  - Latches FpSel=1 for flw/fsw/OP-FP; otherwise FpSel=0.
- **MEMADR**
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Goes to MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD**
  - Drives AdrSrc=1, ResultSrc=00.
  - Goes to MEMWB when mem_ready; otherwise waits.
- **MEMWB**
  - Drives ResultSrc=01.
  - Drives RegWrite=!FpSel and FRegWrite=FpSel.
  - Goes to FETCH.
- **MEMWRITE**
  - Drives AdrSrc=1, ResultSrc=00, MemWrite=1.
  - Goes to FETCH when mem_ready; MemWrite stays high while waiting.
- **EXECUTER**
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Goes to ALUWB.
- **EXECUTEI**
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Goes to ALUWB.
- **LUI**
  - Drives ALUSrcA=11, ALUSrcB=01, ALUOp=00.
  - Goes to ALUWB.
- **ALUWB**
  - Drives ResultSrc=00, RegWrite=1.
  - Goes to FETCH.
- **BEQ**
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - Goes to FETCH.
- **JAL**
  - Drives ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - Goes to ALUWB.
- **FPEXEC**
  - fp_start=1 on the first cycle only, from a registered entry flag.
  - Goes to FPWB when fp_done; otherwise waits.
  - An fp_done that arrives in the same cycle as fp_start is accepted.
- **FPWB**
  - Drives ResultSrc=11, FRegWrite=1.
  - Goes to FETCH.
- With FP_EN=0, opcodes 0000111, 0100111 and 1010011 take the illegal path.
- With MEM_HS=0, every memory state lasts exactly one cycle.
- ImmSrc mapping:
  - 000 for lw, flw, I-type
  - 001 for sw, fsw
  - 010 for beq
  - 011 for jal
  - 100 for lui
  - 000 for every other opcode.

## Timing
- Reset with reset=0 at the clock edge:
  - State goes to FETCH; FpSel and the fp_start entry flag clear.
  - During reset, the FETCH Moore outputs are held but IRWrite and PCWrite are forced to 0.
- Reset asserted mid-instruction aborts the instruction. No write strobe is asserted in the cycle after the reset edge.
- Cycle counts with zero wait:
  - lw 5, flw 5
  - sw 4, fsw 4
  - R 4, I 4, lui 4, jal 4
  - beq 3
  - OP-FP 4 + FPU latency.
- Each memory wait cycle adds one cycle.
- PCWrite is combinational on zero only in BEQ.
- illegal is a Moore pulse in DECODE; the PC has already advanced.

## Test plan
- Reset held 3 cycles, then op=0000011 and mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; ImmSrc=000.
- sw with mem_ready low for 2 cycles in MEMWRITE → MemWrite high for 3 cycles, then FETCH; total 6 cycles.
- beq with zero=1, then with zero=0 → PCWrite=1 and PCWrite=0 respectively in cycle 3; Branch=1 in both.
- OP-FP with fp_done asserted 4 cycles after FPEXEC entry → fp_start exactly one cycle; FRegWrite=1 and ResultSrc=11 in FPWB; RegWrite stays 0.
- FP_EN=0 with op=1010011 → illegal=1 in DECODE, next state FETCH, no write strobes.
- reset=0 asserted in MEMREAD → FETCH next cycle, RegWrite never asserted; lui afterward gives ALUSrcA=11, ImmSrc=100, RegWrite=1 in cycle 4.
